// File: rtl/proc_sequencer.sv
// proc_sequencer: multi-cycle control sequencer for the better_processor
// datapath. Latches an instruction word on a run request and steps
// IDLE -> T1 [-> T2 -> T3], driving the register-file, A/G and bus controls.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   run          start request (sampled in IDLE and in completion steps)
//   din          instruction word / mvi immediate
//   ir_q         latched instruction register
//   en_reg       one-hot register-file write enable (index Rx)
//   en_a, en_g   A and G register load enables
//   add_sub      ALU select, 0 add / 1 subtract
//   bus_sel      bus source: 0-7 Rn, 8 G, 9 din
//   done         pulse in an instruction's final step
//   busy         high whenever not IDLE
//   instr_count  retired-instruction counter (wraps)
module proc_sequencer #(
   parameter int DW   = 16,
   parameter int CNTW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
   input  logic [DW-1:0]   din,
   output logic [DW-1:0]   ir_q,
   output logic [7:0]      en_reg,
   output logic            en_a,
   output logic            en_g,
   output logic            add_sub,
   output logic [3:0]      bus_sel,
   output logic            done,
   output logic            busy,
   output logic [CNTW-1:0] instr_count
);

   typedef enum logic [1:0] {S_IDLE, S_T1, S_T2, S_T3} state_t;

   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   state_t          state_q, state_d;
   logic [DW-1:0]   ir_d;
   logic [CNTW-1:0] cnt_q, cnt_d;
   logic            load;

   logic [2:0] rx, ry, op;
   assign rx = ir_q[15:13];
   assign ry = ir_q[12:10];
   assign op = ir_q[9:7];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ir_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      en_reg  = 8'h00;
      en_a    = 1'b0;
      en_g    = 1'b0;
      add_sub = 1'b0;
      bus_sel = 4'd0;
      done    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (run) begin
               load    = 1'b1;
               state_d = S_T1;
            end
         end
         S_T1: begin
            unique case (op)
               OP_MV: begin
                  bus_sel    = {1'b0, ry};
                  en_reg[rx] = 1'b1;
                  done       = 1'b1;
               end
               OP_MVI: begin
                  bus_sel    = 4'd9;
                  en_reg[rx] = 1'b1;
                  done       = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  bus_sel = {1'b0, rx};
                  en_a    = 1'b1;
                  state_d = S_T2;
               end
               default: done = 1'b1;   // NOP retires with no enables
            endcase
         end
         S_T2: begin
            bus_sel = {1'b0, ry};
            en_g    = 1'b1;
            add_sub = op[0];
            state_d = S_T3;
         end
         S_T3: begin
            bus_sel    = 4'd8;
            en_reg[rx] = 1'b1;
            done       = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      // Completion step: retire, and chain straight into the next
      // instruction if run is still asserted.
      if (done) begin
         load    = run;
         state_d = run ? S_T1 : S_IDLE;
      end
   end

   assign ir_d        = load ? din : ir_q;
   assign cnt_d       = done ? cnt_q + 1'b1 : cnt_q;
   assign busy        = (state_q != S_IDLE);
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_proc_sequencer.sv
module tb_proc_sequencer;

   localparam int DW   = 16;
   localparam int CNTW = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic            run;
   logic [DW-1:0]   din;
   logic [DW-1:0]   ir_q;
   logic [7:0]      en_reg;
   logic            en_a, en_g, add_sub, done, busy;
   logic [3:0]      bus_sel;
   logic [CNTW-1:0] instr_count;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   proc_sequencer #(.DW(DW), .CNTW(CNTW)) dut (
      .clk(clk), .reset(reset), .run(run), .din(din), .ir_q(ir_q),
      .en_reg(en_reg), .en_a(en_a), .en_g(en_g), .add_sub(add_sub),
      .bus_sel(bus_sel), .done(done), .busy(busy), .instr_count(instr_count)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // advance one rising edge, then sit 1ns past it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0; run = 1'b0; din = '0;
      #3;
      chk("rst_busy",  32'(busy), 0);
      chk("rst_ir",    32'(ir_q), 0);
      chk("rst_cnt",   32'(instr_count), 0);
      chk("rst_done",  32'(done), 0);
      chk("rst_bus",   32'(bus_sel), 0);
      step(); step();
      reset = 1'b1;
      step();
      chk("idle_busy", 32'(busy), 0);

      // mvi R1 <- 00AB
      run = 1'b1; din = 16'h2080;
      step();
      din = 16'h00AB;
      chk("mvi_ir",   32'(ir_q), 32'h2080);
      chk("mvi_bus",  32'(bus_sel), 9);
      chk("mvi_en",   32'(en_reg), 32'h02);
      chk("mvi_done", 32'(done), 1);
      chk("mvi_busy", 32'(busy), 1);
      run = 1'b0;
      step();
      chk("mvi_cnt",  32'(instr_count), 1);
      chk("mvi_idle", 32'(busy), 0);
      chk("mvi_ir2",  32'(ir_q), 32'h2080);

      // add R2 <- R2 + R3; run raised during T1/T2 must be ignored
      run = 1'b1; din = 16'h4D00;
      step();
      chk("add1_bus",  32'(bus_sel), 2);
      chk("add1_ena",  32'(en_a), 1);
      chk("add1_en",   32'(en_reg), 0);
      chk("add1_done", 32'(done), 0);
      din = 16'hFFFF;
      step();
      chk("add2_ir",   32'(ir_q), 32'h4D00);
      chk("add2_bus",  32'(bus_sel), 3);
      chk("add2_eng",  32'(en_g), 1);
      chk("add2_as",   32'(add_sub), 0);
      chk("add2_ena",  32'(en_a), 0);
      run = 1'b0;
      step();
      chk("add3_bus",  32'(bus_sel), 8);
      chk("add3_en",   32'(en_reg), 32'h04);
      chk("add3_done", 32'(done), 1);
      chk("add3_eng",  32'(en_g), 0);
      step();
      chk("add_idle",  32'(busy), 0);
      chk("add_cnt",   32'(instr_count), 2);

      // sub R2 <- R2 - R3, run low from T1
      run = 1'b1; din = 16'h4D80;
      step();
      run = 1'b0;
      chk("sub1_ena",  32'(en_a), 1);
      step();
      chk("sub2_as",   32'(add_sub), 1);
      chk("sub2_bus",  32'(bus_sel), 3);
      step();
      chk("sub3_done", 32'(done), 1);
      chk("sub3_en",   32'(en_reg), 32'h04);
      step();
      chk("sub_cnt",   32'(instr_count), 3);

      // back-to-back mv R0<-R5, mv R7<-R0
      run = 1'b1; din = 16'h1400;
      step();
      chk("b2b1_en",   32'(en_reg), 32'h01);
      chk("b2b1_bus",  32'(bus_sel), 5);
      chk("b2b1_done", 32'(done), 1);
      din = 16'hE000;
      step();
      chk("b2b2_ir",   32'(ir_q), 32'hE000);
      chk("b2b2_en",   32'(en_reg), 32'h80);
      chk("b2b2_bus",  32'(bus_sel), 0);
      chk("b2b2_done", 32'(done), 1);
      run = 1'b0;
      step();
      chk("b2b_cnt",   32'(instr_count), 5);

      // NOP op=101
      run = 1'b1; din = 16'h0280;
      step();
      run = 1'b0;
      chk("nop_done",  32'(done), 1);
      chk("nop_en",    32'({en_reg, en_a, en_g}), 0);
      chk("nop_bus",   32'(bus_sel), 0);
      step();
      chk("nop_cnt",   32'(instr_count), 6);

      // reset during T2 of an add
      run = 1'b1; din = 16'h4D00;
      step();
      run = 1'b0;
      step();
      chk("mrst_pre",  32'(en_g), 1);
      #2 reset = 1'b0;
      #1;
      chk("mrst_eng",  32'(en_g), 0);
      chk("mrst_bus",  32'(bus_sel), 0);
      chk("mrst_done", 32'(done), 0);
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_ir",   32'(ir_q), 0);
      chk("mrst_cnt",  32'(instr_count), 0);
      step();
      chk("mrst_hold", 32'(done), 0);
      reset = 1'b1;
      step();
      chk("mrst_idle", 32'(busy), 0);

      // 16 retirements wrap a 4-bit counter
      run = 1'b1; din = 16'h1400;
      for (int i = 0; i < 16; i++) step();
      chk("wrap_15",   32'(instr_count), 15);
      run = 1'b0;
      step();
      chk("wrap_0",    32'(instr_count), 0);
      chk("wrap_idle", 32'(busy), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
